// File: rtl/mul_hilo_stage_pkg.sv
// Shared types and widths for the multiply hi/lo stage.
package mul_hilo_stage_pkg;
    localparam int OP_W   = 16;
    localparam int PROD_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;
endpackage

// File: rtl/mul.sv
// Combinational 16x16 unsigned array multiplier: shift-and-add over the bits of B.
module mul
    import mul_hilo_stage_pkg::*;
(
    output logic [OP_W-1:0] hi,
    output logic [OP_W-1:0] lo,
    input  logic [OP_W-1:0] A,
    input  logic [OP_W-1:0] B
);
    logic [PROD_W-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < OP_W; i++) begin
            if (B[i]) acc = acc + (PROD_W'(A) << i);
        end
    end

    assign {hi, lo} = acc;
endmodule

// File: rtl/mul_hilo_stage.sv
// Handshaked multiply stage: latches operands, waits SETTLE_CYCLES for the array
// multiplier, registers the 32-bit product. MUL_SIGNED_EN adds signed operation.
module mul_hilo_stage
    import mul_hilo_stage_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] A,
    input  logic [OP_W-1:0] B,
    input  logic            signed_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] hi,
    output logic [OP_W-1:0] lo,
    output logic            busy
);
    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic [OP_W-1:0]   a_q, b_q;
    logic [OP_W-1:0]   mul_a, mul_b, prod_hi, prod_lo;
    logic [PROD_W-1:0] prod, prod_fin;
    logic              accept, capture;

    assign accept  = in_valid && in_ready;
    assign capture = (state == SETTLE) && (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETTLE;
            SETTLE:  if (capture) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = in_valid ? SETTLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            cnt <= '0;
            hi  <= '0;
            lo  <= '0;
        end else begin
            if (accept) begin
                a_q <= A;
                b_q <= B;
                cnt <= 4'(SETTLE_CYCLES - 1);
            end else if ((state == SETTLE) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) {hi, lo} <= prod_fin;
        end
    end

`ifdef MUL_SIGNED_EN
    logic sop_q, neg;

    always_ff @(posedge clk) begin
        if (rst)         sop_q <= 1'b0;
        else if (accept) sop_q <= signed_op;
    end

    // Multiply magnitudes; -0x8000 wraps to 0x8000, which is the correct magnitude.
    assign mul_a    = (sop_q && a_q[OP_W-1]) ? -a_q : a_q;
    assign mul_b    = (sop_q && b_q[OP_W-1]) ? -b_q : b_q;
    assign neg      = sop_q && (a_q[OP_W-1] ^ b_q[OP_W-1]);
    assign prod_fin = neg ? -prod : prod;
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;
    assign mul_a    = a_q;
    assign mul_b    = b_q;
    assign prod_fin = prod;
`endif

    mul u_mul (
        .hi (prod_hi),
        .lo (prod_lo),
        .A  (mul_a),
        .B  (mul_b)
    );

    assign prod = {prod_hi, prod_lo};
endmodule
